level_display: RTL and testbench
================================

LEVEL_DISPLAY -- requirements
Module: level_display

Interface
REQ-001 Parameter DecayLength, 17'd39_063: bar fall interval is DecayLength+1 clocks per segment (100 ms at 390.625 kHz).
REQ-002 Parameter HoldLength, 19'd390_625: peak-dot hold time is HoldLength+1 clocks (1 s).
REQ-003 Parameter BlinkHalf, 17'd78_125: clip LED half-period is BlinkHalf+1 clocks (200 ms).
REQ-004 Parameter Brightness, 8'd192: PWM duty is Brightness/256; 0 means LEDs always off.
REQ-005 nReset  input  1  asynchronous active-low reset.
REQ-006 Clk  input  1  system clock, 390.625 kHz, all logic on posedge.
REQ-007 Level  input  4  thermometer level code from the level meter, bit0 = lowest threshold.
REQ-008 Clip  input  1  clip flag from the level meter, already stretched by the meter.
REQ-009 Bar  output  4  registered LED drive, bit i = segment i, active high.
REQ-010 ClipLed  output  1  registered clip LED drive, active high.

Function
REQ-011 Level sampled every clock; N = count of consecutive ones from bit0 (0..4); non-thermometer codes truncate at the first zero (4'b1011 -> N=2).
REQ-012 Display count D (0..4): N>D -> D<=N, DecayCount<=DecayLength; N==D -> DecayCount<=DecayLength; N<D -> if DecayCount==0 then D<=D-1, DecayCount<=DecayLength, else DecayCount<=DecayCount-1.
REQ-013 D decrements by exactly one per DecayLength+1 clocks; never below 0; rise is immediate and unlimited.
REQ-014 Peak P (0..4): N>=P -> P<=N, HoldCount<=HoldLength; else HoldCount==0 -> P<=D (post-update value from REQ-012), HoldCount<=HoldLength; else HoldCount<=HoldCount-1.
REQ-015 P >= D at all times; if D would exceed P in the same cycle, P takes D's new value.
REQ-016 PwmCount: 8-bit free-running counter, wraps 255 -> 0; PwmOn = (PwmCount < Brightness).
REQ-017 Segment i lit when PwmOn and (i < D or (P > 0 and i == P-1)).
REQ-018 Bar registered from the current-cycle registered D, P, PwmCount; Level change reaches Bar 2 clocks after the sampling edge.
REQ-019 Clip blink states: IDLE (ClipLed=0, BlinkCount=BlinkHalf, Phase=1) and BLINK.
REQ-020 IDLE with Clip=1 -> BLINK; lit phase starts at once (ClipLed=PwmOn on the next edge).
REQ-021 In BLINK, BlinkCount decrements each clock; at 0, Phase toggles and BlinkCount<=BlinkHalf; ClipLed = Phase and PwmOn.
REQ-022 BLINK with Clip=0 -> IDLE on the next edge, even mid-phase; ClipLed=0 on that edge.
REQ-023 Clip has no effect on D, P or Bar.

Reset
REQ-024 nReset low asynchronously forces Bar=0, ClipLed=0, D=0, P=0, DecayCount=DecayLength, HoldCount=HoldLength, PwmCount=0, blink FSM=IDLE.
REQ-025 Reset asserted mid-decay, mid-hold or mid-blink clears all state; no residual peak or blink after release.
REQ-026 First posedge after release samples inputs normally.

Verification
REQ-027 Bench parameters: DecayLength=3, HoldLength=7, BlinkHalf=4, Brightness=8'd255, unless stated otherwise.
REQ-028 Level 0000->1111 for 1 clock then 0000 -> Bar=1111 two clocks later; D steps 4,3,2,1,0 every 4 clocks; peak dot Bar[3] stays lit for 8 clocks, then P follows D.
REQ-029 Level=0111 held, then 1111 for 1 clock, then 0111 held -> Bar=1111, then 0111 with Bar[3] dot kept 8 clocks, then Bar=0111 steady.
REQ-030 Level=1011 -> N=2, Bar=0011; Level=1110 -> N=0, Bar=0000 after decay.
REQ-031 Clip=1 held 20 clocks -> ClipLed 1 for 5 clocks, 0 for 5, 1 for 5, 0 for 5; Clip=0 mid-lit-phase -> ClipLed=0 next edge.
REQ-032 Brightness=8'd64, Level=1111 held -> each Bar bit high exactly 64 of every 256 clocks; Brightness=0 -> Bar=0000 always.
REQ-033 nReset pulsed low during decay from D=4 with Clip=1 -> Bar=0000, ClipLed=0 immediately; after release with Level=0000, Clip=0, outputs stay 0.

Source files
------------

// File: rtl/level_display.sv
// Four-segment LED level bar with decaying display, held peak dot and blinking clip LED.
// All LED drive is PWM-dimmed from a free-running 8-bit counter.
module level_display #(
  parameter logic [16:0] DecayLength = 17'd39_063,
  parameter logic [18:0] HoldLength  = 19'd390_625,
  parameter logic [16:0] BlinkHalf   = 17'd78_125,
  parameter logic [7:0]  Brightness  = 8'd192
) (
  input  logic       nReset,
  input  logic       Clk,
  input  logic [3:0] Level,
  input  logic       Clip,
  output logic [3:0] Bar,
  output logic       ClipLed
);

  typedef enum logic {IDLE, BLINK} blink_state_e;

  blink_state_e state_q, state_d;
  logic [3:0]  level_q;
  logic [2:0]  disp_q, disp_d;
  logic [2:0]  peak_q, peak_d;
  logic [16:0] decay_cnt_q, decay_cnt_d;
  logic [18:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]  pwm_q, pwm_d;
  logic [16:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  bar_q, bar_d;
  logic        clip_led_q, clip_led_d;

  logic [2:0]  n;
  logic        run;
  logic        pwm_on;
  logic [2:0]  seg;

  // Count of consecutive ones from bit 0; a non-thermometer code stops at the first zero.
  always_comb begin
    n   = '0;
    run = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      run = run & level_q[i];
      if (run) n = n + 3'd1;
    end
  end

  assign pwm_on = (pwm_q < Brightness);
  assign pwm_d  = pwm_q + 8'd1;

  always_comb begin
    disp_d      = disp_q;
    decay_cnt_d = decay_cnt_q;
    if (n > disp_q) begin
      disp_d      = n;
      decay_cnt_d = DecayLength;
    end else if (n == disp_q) begin
      decay_cnt_d = DecayLength;
    end else if (decay_cnt_q == '0) begin
      disp_d      = disp_q - 3'd1;
      decay_cnt_d = DecayLength;
    end else begin
      decay_cnt_d = decay_cnt_q - 17'd1;
    end

    // Peak falls back onto the already-updated display value when the hold expires.
    peak_d     = peak_q;
    hold_cnt_d = hold_cnt_q;
    if (n >= peak_q) begin
      peak_d     = n;
      hold_cnt_d = HoldLength;
    end else if (hold_cnt_q == '0) begin
      peak_d     = disp_d;
      hold_cnt_d = HoldLength;
    end else begin
      hold_cnt_d = hold_cnt_q - 19'd1;
    end
    if (disp_d > peak_d) peak_d = disp_d;
  end

  always_comb begin
    bar_d = '0;
    seg   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      seg      = 3'(i);
      bar_d[i] = pwm_on && ((seg < disp_q) || ((peak_q != '0) && (seg == peak_q - 3'd1)));
    end
  end

  always_comb begin
    state_d     = state_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    clip_led_d  = 1'b0;
    case (state_q)
      IDLE: begin
        blink_cnt_d = BlinkHalf;
        phase_d     = 1'b1;
        if (Clip) begin
          state_d    = BLINK;
          clip_led_d = pwm_on;
        end
      end
      BLINK: begin
        if (!Clip) begin
          state_d     = IDLE;
          blink_cnt_d = BlinkHalf;
          phase_d     = 1'b1;
        end else begin
          if (blink_cnt_q == '0) begin
            phase_d     = ~phase_q;
            blink_cnt_d = BlinkHalf;
          end else begin
            blink_cnt_d = blink_cnt_q - 17'd1;
          end
          clip_led_d = phase_d & pwm_on;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      level_q     <= '0;
      disp_q      <= '0;
      peak_q      <= '0;
      decay_cnt_q <= DecayLength;
      hold_cnt_q  <= HoldLength;
      pwm_q       <= '0;
      blink_cnt_q <= BlinkHalf;
      phase_q     <= 1'b1;
      bar_q       <= '0;
      clip_led_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= Level;
      disp_q      <= disp_d;
      peak_q      <= peak_d;
      decay_cnt_q <= decay_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      pwm_q       <= pwm_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      bar_q       <= bar_d;
      clip_led_q  <= clip_led_d;
    end
  end

  assign Bar     = bar_q;
  assign ClipLed = clip_led_q;

endmodule

// File: tb/tb_level_display.sv
// Bench for level_display: constant vector tables, hand sequences and randomized
// stimulus compared against an age/time based reference model, on three brightness settings.
module tb_level_display;

  localparam logic [16:0] DL = 17'd3;
  localparam logic [18:0] HL = 19'd7;
  localparam logic [16:0] BH = 17'd4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] level = '0;
  logic       clip  = 1'b0;
  logic [3:0] bar_full, bar_dim, bar_off;
  logic       led_full, led_dim, led_off;

  always #5 clk = ~clk;

  level_display #(.DecayLength(DL), .HoldLength(HL), .BlinkHalf(BH), .Brightness(8'd255)) u_full (
    .nReset(rst_n), .Clk(clk), .Level(level), .Clip(clip), .Bar(bar_full), .ClipLed(led_full));
  level_display #(.DecayLength(DL), .HoldLength(HL), .BlinkHalf(BH), .Brightness(8'd64)) u_dim (
    .nReset(rst_n), .Clk(clk), .Level(level), .Clip(clip), .Bar(bar_dim), .ClipLed(led_dim));
  level_display #(.DecayLength(DL), .HoldLength(HL), .BlinkHalf(BH), .Brightness(8'd0)) u_off (
    .nReset(rst_n), .Clk(clk), .Level(level), .Clip(clip), .Bar(bar_off), .ClipLed(led_off));

  int checks = 0;
  int errors = 0;

  // Reference model: display/peak tracked by how long the input has been below them,
  // blink phase derived from the time since Clip went active.
  int   m_n_reg, m_d, m_p, m_dage, m_hage, m_pwm, m_t;
  bit   m_blink;
  logic [3:0] m_bar_full, m_bar_dim, m_bar_off;
  logic       m_led_full, m_led_dim, m_led_off;

  function automatic int therm_n(input logic [3:0] v);
    int n = 0;
    while (n < 4 && v[n]) n++;
    return n;
  endfunction

  function automatic logic [3:0] exp_bar(input int d, input int p, input bit on);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = on && ((i < d) || (p > 0 && i == p - 1));
    return r;
  endfunction

  task automatic model_reset();
    m_n_reg = 0; m_d = 0; m_p = 0; m_dage = 0; m_hage = 0; m_pwm = 0; m_t = 0;
    m_blink = 0;
    m_bar_full = '0; m_bar_dim = '0; m_bar_off = '0;
    m_led_full = 0; m_led_dim = 0; m_led_off = 0;
  endtask

  task automatic model_edge(input logic [3:0] lvl, input logic c);
    int  n;
    bit  on_full, on_dim, lit;
    on_full = (m_pwm < 255);
    on_dim  = (m_pwm < 64);
    m_bar_full = exp_bar(m_d, m_p, on_full);
    m_bar_dim  = exp_bar(m_d, m_p, on_dim);
    m_bar_off  = '0;
    n = m_n_reg;
    if (n >= m_d) begin
      m_d = n; m_dage = 0;
    end else begin
      m_dage++;
      if (m_dage == int'(DL) + 1) begin m_d--; m_dage = 0; end
    end
    if (n >= m_p) begin
      m_p = n; m_hage = 0;
    end else begin
      m_hage++;
      if (m_hage == int'(HL) + 1) begin m_p = m_d; m_hage = 0; end
    end
    if (m_d > m_p) m_p = m_d;
    if (c) begin
      if (!m_blink) begin m_blink = 1; m_t = 0; end
      else m_t++;
      lit = ((m_t / (int'(BH) + 1)) % 2) == 0;
      m_led_full = lit && on_full;
      m_led_dim  = lit && on_dim;
    end else begin
      m_blink = 0;
      m_led_full = 0;
      m_led_dim  = 0;
    end
    m_led_off = 0;
    m_n_reg = therm_n(lvl);
    m_pwm = (m_pwm + 1) % 256;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(level, clip);
    @(negedge clk);
    check("bar_full", bar_full, m_bar_full);
    check("bar_dim",  bar_dim,  m_bar_dim);
    check("bar_off",  bar_off,  m_bar_off);
    check("led_full", led_full, m_led_full);
    check("led_dim",  led_dim,  m_led_dim);
    check("led_off",  led_off,  m_led_off);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_bar",  bar_full, 4'b0000);
    check("rst_led",  led_full, 1'b0);
    check("rst_dimb", bar_dim,  4'b0000);
    check("rst_diml", led_dim,  1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    level = '0;
    clip  = 1'b0;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] lvl;
    logic       clp;
    logic [3:0] bar;
    logic       led;
    int         reps;
  } vec_t;

  vec_t tbl[9];
  int   cnt_dim[4];
  int   cnt_off;
  int   hold_left;
  logic [3:0] tmp;

  initial begin
    tbl[0] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 1};
    tbl[1] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1};
    tbl[2] = '{4'b0000, 1'b0, 4'b1111, 1'b0, 8};
    tbl[3] = '{4'b0000, 1'b0, 4'b0011, 1'b0, 8};
    tbl[4] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4};
    tbl[5] = '{4'b1011, 1'b0, 4'b0000, 1'b0, 2};
    tbl[6] = '{4'b1011, 1'b0, 4'b0011, 1'b0, 3};
    tbl[7] = '{4'b1110, 1'b0, 4'b0011, 1'b0, 9};
    tbl[8] = '{4'b1110, 1'b0, 4'b0000, 1'b0, 2};

    model_reset();
    @(negedge clk);
    do_reset();

    // Decay staircase, peak hold, and non-thermometer codes.
    for (int e = 0; e < 9; e++) begin
      for (int r = 0; r < tbl[e].reps; r++) begin
        level = tbl[e].lvl;
        clip  = tbl[e].clp;
        cycle();
        check("tbl_bar", bar_full, tbl[e].bar);
        check("tbl_led", led_full, tbl[e].led);
      end
    end

    // Short burst above a steady level leaves a held dot, then settles.
    do_reset();
    level = 4'b0111;
    repeat (4) cycle();
    level = 4'b1111;
    cycle();
    level = 4'b0111;
    repeat (20) cycle();
    check("burst_steady", bar_full, 4'b0111);

    // Clip blink cadence and early release in the lit phase.
    do_reset();
    clip = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      check("blink_seq", led_full, (((k - 1) / 5) % 2 == 0) ? 1'b1 : 1'b0);
    end
    clip = 1'b0;
    cycle();
    check("blink_stop", led_full, 1'b0);
    clip = 1'b1;
    repeat (3) cycle();
    check("blink_lit", led_full, 1'b1);
    clip = 1'b0;
    cycle();
    check("blink_abort", led_full, 1'b0);

    // PWM duty at reduced and zero brightness.
    level = 4'b1111;
    repeat (4) cycle();
    cnt_dim = '{0, 0, 0, 0};
    cnt_off = 0;
    for (int k = 0; k < 256; k++) begin
      cycle();
      for (int b = 0; b < 4; b++) begin
        if (bar_dim[b]) cnt_dim[b]++;
        if (bar_off[b]) cnt_off++;
      end
    end
    for (int b = 0; b < 4; b++) check("pwm64_duty", 32'(cnt_dim[b]), 32'd64);
    check("pwm0_duty", 32'(cnt_off), 32'd0);

    // Randomized run against the reference model.
    hold_left = 0;
    for (int k = 0; k < 2500; k++) begin
      if (hold_left == 0) begin
        if ($urandom_range(0, 9) < 7) begin
          tmp = 4'((1 << $urandom_range(0, 4)) - 1);
        end else begin
          tmp = 4'($urandom);
        end
        level = tmp;
        hold_left = $urandom_range(1, 12);
      end else begin
        hold_left--;
      end
      if ($urandom_range(0, 15) == 0) clip = ~clip;
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle();
    end

    // Reset in the middle of a decay with the clip LED blinking.
    do_reset();
    level = 4'b1111;
    repeat (2) cycle();
    level = 4'b0000;
    clip  = 1'b1;
    repeat (6) cycle();
    check("pre_rst_bar", bar_full, 4'b1111);
    do_reset();
    for (int k = 0; k < 20; k++) begin
      cycle();
      check("post_rst_bar", bar_full, 4'b0000);
      check("post_rst_led", led_full, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
